// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops finish in 1 edge, mul/div iterate one bit per clock.
// Optional divider: define ALU_SEQ_DIV_EN to enable op 17 (otherwise op 17 is an unknown opcode).
module alu_seq #(
    parameter int W          = 64,
    parameter bit SHIFT_FILL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       instr,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W/2-1:0]   value,
    input  logic             highlow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             flag,
    output logic             div_zero,
    output logic             busy
);
    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, result_q, result_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            flag_q, flag_d, dz_q, dz_d, div_q, div_d;
    logic            accept, is_mul, is_div, last, big, alu_flag;
    logic [SW-1:0]   sh;
    logic [W-1:0]    ones, shl, shr, alu_res;
`ifdef ALU_SEQ_DIV_EN
    logic [W:0]      rem_sh, diff;
    logic            ge;
`endif

    // Single-cycle datapath; mul/div opcodes yield 0 here and are filled in by the iteration
    always_comb begin
        ones     = '1;
        sh       = b[SW-1:0];
        big      = b >= W'(W);
        shl      = big ? {W{SHIFT_FILL}} : (a << sh) | (SHIFT_FILL ? ~(ones << sh) : '0);
        shr      = big ? {W{SHIFT_FILL}} : (a >> sh) | (SHIFT_FILL ? ~(ones >> sh) : '0);
        alu_res  = '0;
        alu_flag = 1'b0;
        case (instr)
            6'd0:             alu_res = a + b;
            6'd1:             alu_res = a - b;
            6'd2:             alu_res = shl;
            6'd3:             alu_res = shr;
            6'd4, 6'd6, 6'd7: alu_res = a;
            6'd5:             alu_res = highlow ? {value, a[W/2-1:0]} : {a[W-1:W/2], value};
            6'd8:             alu_flag = a == b;
            6'd9:             alu_flag = a < b;
            6'd10:            alu_flag = a > b;
            default:          alu_res = '0;
        endcase
    end

    // Next-state and datapath: accept in IDLE, iterate in BUSY, drain in DONE
    always_comb begin
        is_mul   = instr == 6'd16;
`ifdef ALU_SEQ_DIV_EN
        is_div   = instr == 6'd17;
        rem_sh   = {acc_q, opa_q[W-1]};
        diff     = rem_sh - {1'b0, opb_q};
        ge       = rem_sh >= {1'b0, opb_q};
`else
        is_div   = 1'b0;
`endif
        accept   = in_valid & in_ready;
        last     = cnt_q == SW'(W-1);
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        result_d = result_q;
        flag_d   = flag_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d  = (is_mul | is_div) ? BUSY : DONE;
                opa_d    = a;
                opb_d    = b;
                acc_d    = '0;
                cnt_d    = '0;
                div_d    = is_div;
                result_d = alu_res;
                flag_d   = alu_flag;
                dz_d     = is_div & ~|b;
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
`ifdef ALU_SEQ_DIV_EN
                if (div_q) begin
                    acc_d = ge ? diff[W-1:0] : rem_sh[W-1:0];
                    opa_d = {opa_q[W-2:0], ge};
                end else
`endif
                begin
                    acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if (last) begin
                    state_d  = DONE;
                    result_d = div_q ? opa_d : acc_d;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            dz_q     <= dz_d;
        end
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        busy      = state_q == BUSY;
        result    = result_q;
        flag      = flag_q;
        div_zero  = dz_q;
    end
endmodule
